rs_decode_sequencer: RTL
========================

# rs_decode_sequencer

Top-level controller for the Reed-Solomon decoder peripheral. It sequences four datapath stages (0 syndrome, 1 key equation, 2 root search, 3 error correction) on one host command: clear, start, wait-for-done per stage, with early exit, failure detection, per-stage timeout and abort. It sits between the TinyQV register interface and the decoder stage modules. It is the only source of the stage clear and start strobes.

## Interface
- MAX_ERRORS, 16, maximum correctable symbol errors; sets the width of degree and count fields to DW = $clog2(MAX_ERRORS+1).
- TIMEOUT, 4096, maximum cycles spent in the WAIT phase of any one stage; must be ≥ 2.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_start  in  1  one-cycle request to decode the loaded codeword
- cmd_abort  in  1  one-cycle request to cancel a running decode
- irq_clr  in  1  clears irq
- stage_clr  out  4  one-hot, one-cycle re-initialise strobe per stage
- stage_start  out  4  one-hot, one-cycle start strobe per stage
- stage_done  in  4  per-stage completion; level or pulse, sampled only for the active stage
- syndrome_zero  in  1  all syndromes zero; valid with stage_done[0]
- locator_degree  in  DW  error-locator degree; valid with stage_done[1]
- root_count  in  DW  roots found; valid with stage_done[2]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- irq  out  1  set with done, held until irq_clr
- status  out  2  00 clean, 01 corrected, 10 uncorrectable, 11 timeout/abort
- err_count  out  DW  number of corrected symbols
- fail_stage  out  2  index of the stage active at failure; 0 otherwise

## Operation
- States: IDLE, RUN, FIN. RUN carries stage index s (0..3) and phase p ∈ {CLR, START, WAIT}.
- In IDLE, cmd_start goes to RUN, s=0, p=CLR. It also clears status, err_count and fail_stage. cmd_start outside IDLE is ignored.
- RUN, p=CLR: stage_clr[s]=1 for one cycle, then go to START.
- RUN, p=START: stage_start[s]=1 for one cycle, then go to WAIT. The timeout counter loads 0.
- RUN, p=WAIT: the counter increments each cycle. The block reacts to stage_done[s]; stage_done bits for other stages are ignored.
  - s=0 with syndrome_zero=1: go to FIN, status 00, err_count 0.
  - s=0 with syndrome_zero=0: go to s=1, CLR.
  - s=1: latch locator_degree into deg_q. If deg_q > MAX_ERRORS, or deg_q = 0, go to FIN with status 10 and fail_stage 1. Otherwise go to s=2.
  - s=2: if root_count ≠ deg_q, go to FIN with status 10 and fail_stage 2. Otherwise go to s=3.
  - s=3: go to FIN with status 01 and err_count = deg_q.
- Timeout: if the counter reaches TIMEOUT-1 without stage_done[s], go to FIN with status 11 and fail_stage = s.
- Abort: cmd_abort in RUN asserts stage_clr = 4'b1111 for one cycle, then goes to FIN with status 11 and fail_stage = s.
- FIN lasts one cycle: done=1, irq is set, busy=1. The next state is IDLE.
- Arithmetic: deg_q comparisons are unsigned, DW bits wide. The timeout counter is $clog2(TIMEOUT) bits and saturates.

## Timing
- Reset values: state IDLE, all strobes 0, busy 0, done 0, irq 0, status 00, err_count 0, fail_stage 0, deg_q 0.
- All outputs are registered.
- cmd_start sampled at edge T0 gives stage_clr[0] in T1, stage_start[0] in T2, and WAIT from T3.
- stage_done[s] sampled at edge Tn gives the next stage's CLR, or FIN, in Tn+1.
- With zero-latency stages (done already high in the first WAIT cycle), a full correction takes 13 cycles from cmd_start to done. A clean codeword takes 4 cycles.
- Simultaneous events:
  - abort and stage_done in the same cycle: abort wins.
  - timeout and stage_done in the same cycle: done wins.
  - irq_clr and a set in the same cycle: the set wins.
  - cmd_start in the FIN cycle: ignored.
- Reset mid-decode returns to IDLE immediately without stage_clr. The stages are re-initialised by the next decode's CLR phase.

## Structure
- Shared package rs_pkg holds:
  - state and phase encodings;
  - stage index constants SYN=0, KEY=1, ROOT=2, CORR=3;
  - status codes ST_CLEAN, ST_CORR, ST_UNCORR, ST_TMO;
  - DW derivation.
- One sub-module: rs_stage_timer, the loadable saturating counter with a timeout flag, parameterised by TIMEOUT.

## Test plan
- Clean codeword: start; stage 0 done after 5 cycles with syndrome_zero=1 → done, status 00, err_count 0; stages 1–3 never strobed.
- Correction: stage 1 gives locator_degree=3, stage 2 gives root_count=3 → status 01, err_count 3, irq=1 until irq_clr.
- Root mismatch: locator_degree=4, root_count=2 → status 10, fail_stage 2; stage_start[3] never asserted.
- Timeout: TIMEOUT=16, stage 2 never done → done exactly 16 WAIT cycles after stage_start[2]; status 11, fail_stage 2.
- Abort racing done: cmd_abort in the same cycle as stage_done[1] → stage_clr=4'b1111 for one cycle, then status 11, fail_stage 1.
- Start while busy, and reset mid-run: a second cmd_start is ignored; rst during s=2 WAIT gives all outputs 0, and a subsequent start begins at stage_clr[0].

Source files
------------

// File: rtl/rs_pkg.sv
// Shared encodings for the Reed-Solomon decode sequencer: FSM states and phases,
// stage indices, status codes and the degree-field width helper.
package rs_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } rs_state_t;

  // PH_ABORT is the one-cycle all-stage clear that follows a host abort.
  typedef enum logic [1:0] {
    PH_CLR   = 2'd0,
    PH_START = 2'd1,
    PH_WAIT  = 2'd2,
    PH_ABORT = 2'd3
  } rs_phase_t;

  localparam logic [1:0] SYN  = 2'd0;
  localparam logic [1:0] KEY  = 2'd1;
  localparam logic [1:0] ROOT = 2'd2;
  localparam logic [1:0] CORR = 2'd3;

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_CORR   = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;
  localparam logic [1:0] ST_TMO    = 2'b11;

  typedef struct packed {
    rs_state_t state;
    rs_phase_t phase;
    logic [1:0] stage;
  } rs_dbg_t;

  function automatic int calc_dw(input int max_errors);
    return $clog2(max_errors + 1);
  endfunction

  function automatic logic [3:0] stage_onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/rs_stage_timer.sv
// Per-stage WAIT timer: loads zero, counts while enabled, saturates at TIMEOUT-1
// and flags expiry once the last permitted WAIT cycle is reached.
module rs_stage_timer
  import rs_pkg::*;
#(
  parameter int  TIMEOUT = 4096,
  localparam int CW      = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/rs_decode_sequencer.sv
// Reed-Solomon decode sequencer: walks syndrome, key equation, root search and
// correction stages with clear/start/wait phases, early exit, timeout and abort.
module rs_decode_sequencer
  import rs_pkg::*;
#(
  parameter int  MAX_ERRORS = 16,
  parameter int  TIMEOUT    = 4096,
  localparam int DW         = calc_dw(MAX_ERRORS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_start,
  input  logic          cmd_abort,
  input  logic          irq_clr,
  output logic [3:0]    stage_clr,
  output logic [3:0]    stage_start,
  input  logic [3:0]    stage_done,
  input  logic          syndrome_zero,
  input  logic [DW-1:0] locator_degree,
  input  logic [DW-1:0] root_count,
  output logic          busy,
  output logic          done,
  output logic          irq,
  output logic [1:0]    status,
  output logic [DW-1:0] err_count,
  output logic [1:0]    fail_stage,
  output rs_dbg_t       dbg
);

  localparam logic [DW-1:0] MAX_DEG = DW'(MAX_ERRORS);

  rs_state_t     state;
  rs_phase_t     phase;
  logic [1:0]    stage;
  logic [DW-1:0] deg_q;

  logic          t_load;
  logic          t_en;
  logic          tmo;

  logic          fin_req;
  logic          adv;
  logic [1:0]    fin_status;
  logic [1:0]    fin_fail;
  logic [DW-1:0] fin_err;
  logic          abort_req;

  // Stage handshake: stage_start[s] is a one-cycle strobe issued after stage_clr[s];
  // stage_done[s] (level or pulse) is only looked at in WAIT for the active stage s.
  assign t_load    = (state == S_RUN) && (phase == PH_START);
  assign t_en      = (state == S_RUN) && (phase == PH_WAIT);
  assign abort_req = cmd_abort && (phase != PH_ABORT);

  rs_stage_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (t_load),
    .en     (t_en),
    .expired(tmo)
  );

  always_comb begin
    fin_req    = 1'b0;
    adv        = 1'b0;
    fin_status = ST_CLEAN;
    fin_fail   = SYN;
    fin_err    = '0;
    if (phase == PH_ABORT) begin
      fin_req    = 1'b1;
      fin_status = ST_TMO;
      fin_fail   = stage;
    end else if (phase == PH_WAIT) begin
      // A completion in the last permitted WAIT cycle beats the timeout.
      if (stage_done[stage]) begin
        case (stage)
          SYN: begin
            if (syndrome_zero) fin_req = 1'b1;
            else               adv     = 1'b1;
          end
          KEY: begin
            if ((locator_degree > MAX_DEG) || (locator_degree == '0)) begin
              fin_req    = 1'b1;
              fin_status = ST_UNCORR;
              fin_fail   = KEY;
            end else begin
              adv = 1'b1;
            end
          end
          ROOT: begin
            if (root_count != deg_q) begin
              fin_req    = 1'b1;
              fin_status = ST_UNCORR;
              fin_fail   = ROOT;
            end else begin
              adv = 1'b1;
            end
          end
          default: begin
            fin_req    = 1'b1;
            fin_status = ST_CORR;
            fin_err    = deg_q;
          end
        endcase
      end else if (tmo) begin
        fin_req    = 1'b1;
        fin_status = ST_TMO;
        fin_fail   = stage;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      phase       <= PH_CLR;
      stage       <= SYN;
      deg_q       <= '0;
      stage_clr   <= '0;
      stage_start <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      irq         <= 1'b0;
      status      <= ST_CLEAN;
      err_count   <= '0;
      fail_stage  <= SYN;
    end else begin
      stage_clr   <= '0;
      stage_start <= '0;
      done        <= 1'b0;
      if (irq_clr) irq <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_start) begin
            state      <= S_RUN;
            phase      <= PH_CLR;
            stage      <= SYN;
            stage_clr  <= stage_onehot(SYN);
            busy       <= 1'b1;
            status     <= ST_CLEAN;
            err_count  <= '0;
            fail_stage <= SYN;
          end
        end
        S_RUN: begin
          if ((phase == PH_WAIT) && (stage == KEY) && stage_done[KEY]) begin
            deg_q <= locator_degree;
          end
          if (abort_req) begin
            phase     <= PH_ABORT;
            stage_clr <= 4'b1111;
          end else if (fin_req) begin
            state      <= S_FIN;
            done       <= 1'b1;
            irq        <= 1'b1;
            status     <= fin_status;
            err_count  <= fin_err;
            fail_stage <= fin_fail;
          end else if (adv) begin
            stage     <= stage + 2'd1;
            phase     <= PH_CLR;
            stage_clr <= stage_onehot(stage + 2'd1);
          end else if (phase == PH_CLR) begin
            phase       <= PH_START;
            stage_start <= stage_onehot(stage);
          end else if (phase == PH_START) begin
            phase <= PH_WAIT;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          phase <= PH_CLR;
          stage <= SYN;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg = '{state: state, phase: phase, stage: stage};

endmodule
